// File: rtl/apb_seq_pkg.sv
// Shared types for the APB sequencing master: FSM states, command op codes
// and response error codes.
package apb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    GAP    = 3'd3,
    RESP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SLVERR  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_POLL    = 2'b11
  } err_e;

endpackage

// File: rtl/apb_seq_master_if.sv
// Command, response and APB bus signals of the sequencing master.
// The master modport is the design's view, slave is the environment's view.
interface apb_seq_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] cmd_mask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_seq_wdog.sv
// Wait-cycle watchdog: counts ACCESS cycles with PREADY low and flags the
// cycle on which the count reaches TIMEOUT_CYCLES (0 disables it).
module apb_seq_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic SYSCLK_apb,
  input  logic PRESETN,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] wait_cnt;

  // expire fires on the wait cycle whose increment would reach the limit
  assign expire = (TIMEOUT_CYCLES != 0) && count && (wait_cnt == CW'(LIMIT));

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      wait_cnt <= '0;
    end else if (load) begin
      wait_cnt <= '0;
    end else if (count && !expire && (TIMEOUT_CYCLES != 0)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/apb_seq_master.sv
// Command-driven APB master: single read/write transfers and polled reads
// that repeat until (PRDATA & mask) == (wdata & mask) or POLL_MAX attempts.
module apb_seq_master
  import apb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int POLL_MAX       = 1023
) (
  input logic              SYSCLK_apb,
  input logic              PRESETN,
  apb_seq_master_if.master bus
);
  state_e                state;
  op_e                   op_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [15:0]           poll_cnt;
  logic                  wd_load;
  logic                  wd_count;
  logic                  wd_expire;
  logic                  poll_hit;

  assign wd_load  = (state == SETUP);
  assign wd_count = (state == ACCESS) && !bus.PREADY;
  assign poll_hit = ((bus.PRDATA & mask_q) == (wdata_q & mask_q));

  apb_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .SYSCLK_apb(SYSCLK_apb),
    .PRESETN   (PRESETN),
    .load      (wd_load),
    .count     (wd_count),
    .expire    (wd_expire)
  );

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      state         <= IDLE;
      op_q          <= OP_READ;
      wdata_q       <= '0;
      mask_q        <= '0;
      poll_cnt      <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= ERR_OK;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            op_q          <= op_e'(bus.cmd_op);
            wdata_q       <= bus.cmd_wdata;
            mask_q        <= bus.cmd_mask;
            poll_cnt      <= 16'd1;
            if (bus.cmd_op == OP_RSVD) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= ERR_SLVERR;
              bus.rsp_rdata <= '0;
            end else begin
              state       <= SETUP;
              bus.PSEL    <= 1'b1;
              bus.PENABLE <= 1'b0;
              bus.PADDR   <= ADDR_WIDTH'(bus.cmd_addr);
              bus.PWRITE  <= (bus.cmd_op == OP_WRITE);
              bus.PWDATA  <= (bus.cmd_op == OP_WRITE) ? bus.cmd_wdata : '0;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PENABLE <= 1'b0;
            if (op_q == OP_POLL && !bus.PSLVERR && !poll_hit &&
                poll_cnt < 16'(POLL_MAX)) begin
              state    <= GAP;
              bus.PSEL <= 1'b0;
              poll_cnt <= poll_cnt + 16'd1;
            end else begin
              state         <= RESP;
              bus.PSEL      <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= (op_q == OP_WRITE) ? '0 : bus.PRDATA;
              if (bus.PSLVERR)
                bus.rsp_err <= ERR_SLVERR;
              else if (op_q == OP_POLL && !poll_hit)
                bus.rsp_err <= ERR_POLL;
              else
                bus.rsp_err <= ERR_OK;
            end
          end else if (wd_expire) begin
            state         <= RESP;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= ERR_TIMEOUT;
          end
        end
        GAP: begin
          state    <= SETUP;
          bus.PSEL <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_seq_master.sv
// Directed bench: instance a uses default parameters, instance b uses a short
// timeout (4) and poll limit (2).
module tb_apb_seq_master;
  logic SYSCLK_apb = 1'b0;
  logic PRESETN    = 1'b0;
  int   vec_cnt     = 0;
  int   miscompares = 0;
  int   reads;
  int   gaps;
  int   en_cnt;

  apb_seq_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) a_if ();
  apb_seq_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b_if ();

  apb_seq_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut_a (
    .SYSCLK_apb(SYSCLK_apb),
    .PRESETN   (PRESETN),
    .bus       (a_if)
  );

  apb_seq_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .POLL_MAX(2)) dut_b (
    .SYSCLK_apb(SYSCLK_apb),
    .PRESETN   (PRESETN),
    .bus       (b_if)
  );

  always #5 SYSCLK_apb = ~SYSCLK_apb;

  task automatic tick();
    @(posedge SYSCLK_apb);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single edge; the DUT must be idle and ready.
  task automatic applyStimulus(input bit to_b, input logic [1:0] op, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [31:0] mask);
    if (to_b) begin
      checkOutput("b_cmd_ready_before", 32'(b_if.cmd_ready), 32'd1);
      b_if.cmd_valid = 1'b1; b_if.cmd_op = op; b_if.cmd_addr = addr;
      b_if.cmd_wdata = wdata; b_if.cmd_mask = mask;
    end else begin
      checkOutput("a_cmd_ready_before", 32'(a_if.cmd_ready), 32'd1);
      a_if.cmd_valid = 1'b1; a_if.cmd_op = op; a_if.cmd_addr = addr;
      a_if.cmd_wdata = wdata; a_if.cmd_mask = mask;
    end
    tick();
    a_if.cmd_valid = 1'b0;
    b_if.cmd_valid = 1'b0;
  endtask

  task automatic finishResponse(input bit to_b);
    if (to_b) b_if.rsp_ready = 1'b1; else a_if.rsp_ready = 1'b1;
    tick();
    a_if.rsp_ready = 1'b0;
    b_if.rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 32'(to_b ? b_if.rsp_valid : a_if.rsp_valid), 32'd0);
    checkOutput("cmd_ready_back", 32'(to_b ? b_if.cmd_ready : a_if.cmd_ready), 32'd1);
  endtask

  initial begin
    a_if.cmd_valid = 0; a_if.cmd_op = 0; a_if.cmd_addr = 0; a_if.cmd_wdata = 0; a_if.cmd_mask = 0;
    a_if.rsp_ready = 0; a_if.PRDATA = 0; a_if.PREADY = 1; a_if.PSLVERR = 0;
    b_if.cmd_valid = 0; b_if.cmd_op = 0; b_if.cmd_addr = 0; b_if.cmd_wdata = 0; b_if.cmd_mask = 0;
    b_if.rsp_ready = 0; b_if.PRDATA = 0; b_if.PREADY = 1; b_if.PSLVERR = 0;

    tick();
    tick();
    checkOutput("rst_psel", 32'(a_if.PSEL), 32'd0);
    checkOutput("rst_penable", 32'(a_if.PENABLE), 32'd0);
    checkOutput("rst_pwrite", 32'(a_if.PWRITE), 32'd0);
    checkOutput("rst_paddr", 32'(a_if.PADDR), 32'd0);
    checkOutput("rst_pwdata", a_if.PWDATA, 32'd0);
    checkOutput("rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", a_if.rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", 32'(a_if.rsp_err), 32'd0);
    checkOutput("rst_cmd_ready", 32'(a_if.cmd_ready), 32'd0);
    PRESETN = 1'b1;
    #1;
    checkOutput("cmd_ready_before_edge", 32'(a_if.cmd_ready), 32'd0);
    tick();
    checkOutput("cmd_ready_first_edge", 32'(a_if.cmd_ready), 32'd1);

    // Write, PREADY tied high: SETUP, ACCESS, then response
    applyStimulus(0, 2'b01, 8'h01, 32'h0000_00A5, 32'h0);
    checkOutput("wr_setup_psel", 32'(a_if.PSEL), 32'd1);
    checkOutput("wr_setup_penable", 32'(a_if.PENABLE), 32'd0);
    checkOutput("wr_setup_pwrite", 32'(a_if.PWRITE), 32'd1);
    checkOutput("wr_setup_paddr", 32'(a_if.PADDR), 32'h01);
    checkOutput("wr_setup_pwdata", a_if.PWDATA, 32'h0000_00A5);
    checkOutput("wr_setup_cmd_ready", 32'(a_if.cmd_ready), 32'd0);
    tick();
    checkOutput("wr_access_psel", 32'(a_if.PSEL), 32'd1);
    checkOutput("wr_access_penable", 32'(a_if.PENABLE), 32'd1);
    checkOutput("wr_access_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    tick();
    checkOutput("wr_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
    checkOutput("wr_rsp_psel", 32'(a_if.PSEL), 32'd0);
    checkOutput("wr_rsp_err", 32'(a_if.rsp_err), 32'd0);
    checkOutput("wr_rsp_rdata", a_if.rsp_rdata, 32'd0);
    tick();
    checkOutput("wr_rsp_held", 32'(a_if.rsp_valid), 32'd1);
    finishResponse(0);

    // Read with three wait states
    a_if.PREADY = 1'b0;
    applyStimulus(0, 2'b00, 8'h00, 32'hFFFF_FFFF, 32'h0);
    checkOutput("rd_setup_pwdata", a_if.PWDATA, 32'd0);
    checkOutput("rd_setup_pwrite", 32'(a_if.PWRITE), 32'd0);
    tick();
    en_cnt = 0;
    for (int i = 0; i < 12 && a_if.PENABLE; i++) begin
      en_cnt++;
      if (en_cnt == 4) begin
        a_if.PREADY = 1'b1;
        a_if.PRDATA = 32'h1234_5678;
      end
      tick();
    end
    checkOutput("rd_penable_cycles", 32'(en_cnt), 32'd4);
    checkOutput("rd_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
    checkOutput("rd_rsp_rdata", a_if.rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_err", 32'(a_if.rsp_err), 32'd0);
    finishResponse(0);

    // Poll matching on the third read
    a_if.PRDATA = 32'h0;
    applyStimulus(0, 2'b10, 8'h02, 32'h1, 32'h1);
    checkOutput("poll_setup_pwdata", a_if.PWDATA, 32'd0);
    reads = 0;
    gaps  = 0;
    for (int i = 0; i < 40 && !a_if.rsp_valid; i++) begin
      if (a_if.PSEL && a_if.PENABLE) begin
        a_if.PRDATA = (reads == 2) ? 32'h1 : 32'h0;
        reads++;
      end else if (!a_if.PSEL) begin
        gaps++;
      end
      tick();
    end
    checkOutput("poll_reads", 32'(reads), 32'd3);
    checkOutput("poll_gaps", 32'(gaps), 32'd2);
    checkOutput("poll_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
    checkOutput("poll_rsp_rdata", a_if.rsp_rdata, 32'h1);
    checkOutput("poll_rsp_err", 32'(a_if.rsp_err), 32'd0);
    finishResponse(0);

    // Write answered with PSLVERR
    a_if.PSLVERR = 1'b1;
    applyStimulus(0, 2'b01, 8'h04, 32'hDEAD_BEEF, 32'h0);
    tick();
    tick();
    checkOutput("slverr_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
    checkOutput("slverr_rsp_err", 32'(a_if.rsp_err), 32'd1);
    checkOutput("slverr_rsp_rdata", a_if.rsp_rdata, 32'd0);
    a_if.PSLVERR = 1'b0;
    finishResponse(0);

    // Reserved op: straight to response, no bus activity
    applyStimulus(0, 2'b11, 8'h05, 32'h1, 32'h1);
    checkOutput("rsvd_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
    checkOutput("rsvd_psel", 32'(a_if.PSEL), 32'd0);
    checkOutput("rsvd_rsp_err", 32'(a_if.rsp_err), 32'd1);
    checkOutput("rsvd_rsp_rdata", a_if.rsp_rdata, 32'd0);
    finishResponse(0);

    // Timeout on instance b after four wait cycles
    b_if.PREADY = 1'b0;
    applyStimulus(1, 2'b00, 8'h03, 32'h0, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 20 && b_if.PSEL; i++) begin
      if (b_if.PENABLE) en_cnt++;
      tick();
    end
    checkOutput("to_penable_cycles", 32'(en_cnt), 32'd4);
    checkOutput("to_psel", 32'(b_if.PSEL), 32'd0);
    checkOutput("to_rsp_valid", 32'(b_if.rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(b_if.rsp_err), 32'd2);
    checkOutput("to_rsp_rdata", b_if.rsp_rdata, 32'd0);
    finishResponse(1);

    // Poll on instance b that never matches: expires after two reads
    b_if.PREADY = 1'b1;
    applyStimulus(1, 2'b10, 8'h06, 32'h0000_005A, 32'h0000_00FF);
    reads = 0;
    gaps  = 0;
    for (int i = 0; i < 40 && !b_if.rsp_valid; i++) begin
      if (b_if.PSEL && b_if.PENABLE) begin
        b_if.PRDATA = (reads == 0) ? 32'h10 : 32'h20;
        reads++;
      end else if (!b_if.PSEL) begin
        gaps++;
      end
      tick();
    end
    checkOutput("pexp_reads", 32'(reads), 32'd2);
    checkOutput("pexp_gaps", 32'(gaps), 32'd1);
    checkOutput("pexp_rsp_valid", 32'(b_if.rsp_valid), 32'd1);
    checkOutput("pexp_rsp_err", 32'(b_if.rsp_err), 32'd3);
    checkOutput("pexp_rsp_rdata", b_if.rsp_rdata, 32'h20);
    finishResponse(1);

    // Reset pulse in the middle of an ACCESS phase
    a_if.PREADY = 1'b0;
    applyStimulus(0, 2'b00, 8'h07, 32'h0, 32'h0);
    tick();
    checkOutput("mid_penable", 32'(a_if.PENABLE), 32'd1);
    #2;
    PRESETN = 1'b0;
    #1;
    checkOutput("mid_rst_psel", 32'(a_if.PSEL), 32'd0);
    checkOutput("mid_rst_penable", 32'(a_if.PENABLE), 32'd0);
    checkOutput("mid_rst_paddr", 32'(a_if.PADDR), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(a_if.cmd_ready), 32'd0);
    a_if.PREADY = 1'b1;
    tick();
    tick();
    PRESETN = 1'b1;
    #1;
    checkOutput("mid_rel_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    tick();
    checkOutput("mid_rel_cmd_ready", 32'(a_if.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_no_rsp", 32'(a_if.rsp_valid), 32'd0);
      checkOutput("mid_no_psel", 32'(a_if.PSEL), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
